alu_cmd_scheduler: RTL and testbench

// - Shares one ALU between two requesters. Round-robin arbitration, one command in flight.
// - Drives the ALU enable/operand/op-select inputs and holds them for a fixed window.
// - Samples the ALU result at the end of that window and returns it with the requester ID.
// - Sits between the command sources and the ALU in the datapath.

---
 rtl/alu_cmd_scheduler.sv | 139 +++++++++++++
 tb/tb_alu_cmd_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler
//   Arbitrates two command sources round-robin onto a single shared ALU. Only
//   one command is in flight at a time. Each command's operands and op selects
//   are held on the ALU inputs for HOLD_CYCLES cycles. The ALU result is
//   captured at the end of that window and returned with the requester ID.
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   reqN_valid/ready              command handshake for requester N (N=0,1)
//   reqN_mode/op/a/b              command: operand enables, op select, operands
//   alu_en, alu_op1_en/op2_en     ALU enable and per-operand enables
//   alu_operand1/2, alu_op1/2_op  operands and op selects to the ALU
//   alu_result                    ALU result (DATA_WIDTH+1 bits, signed)
//   rsp_valid/ready/id/data/err   response handshake and payload
//   busy                          state is not IDLE
//   done_cnt                      completed response handshakes, wraps
//
// state | meaning
// IDLE  | arbitrating; reqN_ready may assert
// ISSUE | command driven onto the ALU for HOLD_CYCLES cycles
// RESP  | response pending until rsp_ready
module alu_cmd_scheduler #(
  parameter int DATA_WIDTH  = 5,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_mode,
  input  logic [2:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_mode,
  input  logic [2:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  alu_en,
  output logic                  alu_op1_en,
  output logic                  alu_op2_en,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [2:0]            alu_op1_op,
  output logic [1:0]            alu_op2_op,
  input  logic [DATA_WIDTH:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH:0]   rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_cnt
);

  localparam int CW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_id;
  logic                  accept, acc_id;
  logic [1:0]            sel_mode;
  logic [1:0]            mode_r;
  logic [2:0]            op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]         hold_cnt;
  logic                  hold_done;

  // last_id resets to 1 so req0 wins the first tie.
  assign req0_ready = (state == IDLE) & req0_valid & (~req1_valid | last_id);
  assign req1_ready = (state == IDLE) & req1_valid & (~req0_valid | ~last_id);
  assign accept     = req0_ready | req1_ready;
  assign acc_id     = req1_ready;
  assign sel_mode   = acc_id ? req1_mode : req0_mode;
  assign hold_done  = (hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_mode == 2'b00) ? RESP : ISSUE;
      ISSUE:   if (hold_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id  <= 1'b1;
      mode_r   <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      hold_cnt <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        last_id  <= acc_id;
        rsp_id   <= acc_id;
        mode_r   <= sel_mode;
        op_r     <= acc_id ? req1_op : req0_op;
        a_r      <= acc_id ? req1_a : req0_a;
        b_r      <= acc_id ? req1_b : req0_b;
        hold_cnt <= CW'(HOLD_CYCLES - 1);
        // Illegal mode skips the ALU; the error response carries zero data.
        rsp_err  <= (sel_mode == 2'b00);
        if (sel_mode == 2'b00) rsp_data <= '0;
      end
      if (state == ISSUE) begin
        if (hold_done) rsp_data <= alu_result;
        else           hold_cnt <= hold_cnt - 1'b1;
      end
      if ((state == RESP) && rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  // Operand/op outputs are straight from the command register so they stay
  // stable through ISSUE and keep their last values in RESP and IDLE.
  assign alu_en       = (state == ISSUE);
  assign alu_op1_en   = alu_en & mode_r[1];
  assign alu_op2_en   = alu_en & mode_r[0];
  assign alu_operand1 = a_r;
  assign alu_operand2 = b_r;
  assign alu_op1_op   = op_r;
  assign alu_op2_op   = op_r[1:0];
  assign rsp_valid    = (state == RESP);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed bench for alu_cmd_scheduler with a small ALU model that only
// presents a correct result on the last cycle of the hold window.
module tb_alu_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_mode [2];
  logic [2:0] req_op [2];
  logic [4:0] req_a [2];
  logic [4:0] req_b [2];
  logic       alu_en, alu_op1_en, alu_op2_en;
  logic [4:0] alu_operand1, alu_operand2;
  logic [2:0] alu_op1_op;
  logic [1:0] alu_op2_op;
  logic [5:0] alu_result;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [5:0] rsp_data;
  logic [7:0] done_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_mode(req_mode[0]),
    .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_mode(req_mode[1]),
    .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .alu_en(alu_en), .alu_op1_en(alu_op1_en), .alu_op2_en(alu_op2_en),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_op1_op(alu_op1_op), .alu_op2_op(alu_op2_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
  );

  // ALU model: garbage except on the third consecutive alu_en cycle.
  always @(posedge clk) en_cnt <= alu_en ? en_cnt + 1 : 0;

  always_comb begin
    logic signed [5:0] sa, sb, m;
    sa = {alu_operand1[4], alu_operand1};
    sb = {alu_operand2[4], alu_operand2};
    m  = '0;
    if (alu_op1_en && !alu_op2_en) m = (alu_op1_op == 3'd1) ? sa - sb : sa + sb;
    else if (alu_op1_en && alu_op2_en) m = (alu_op2_op == 2'd3) ? sb + 6'sd2 : sa;
    else if (alu_op2_en) m = sb;
    alu_result = (alu_en && en_cnt == 2) ? m : 6'h15;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] mode, input logic [2:0] op,
                         input logic [4:0] a, input logic [4:0] b);
    req_mode[id] = mode;
    req_op[id]   = op;
    req_a[id]    = a;
    req_b[id]    = b;
  endtask

  task automatic run_cmd(input int id, input logic [1:0] mode, input logic [2:0] op,
                         input logic [4:0] a, input logic [4:0] b, input logic [5:0] exp_data);
    set_req(id, mode, op, a, b);
    req_valid[id] = 1'b1;
    #1;
    check("req_ready", req_ready, (id == 1) ? 2'b10 : 2'b01);
    step(1);
    req_valid[id] = 1'b0;
    check("busy_after_accept", busy, 1);
    if (mode != 2'b00) begin
      for (int i = 0; i < 3; i++) begin
        check("alu_en", alu_en, 1);
        check("alu_enables", {alu_op1_en, alu_op2_en}, mode);
        check("alu_operands", {alu_operand1, alu_operand2}, {a, b});
        check("alu_ops", {alu_op1_op, alu_op2_op}, {op, op[1:0]});
        check("rsp_valid_in_issue", rsp_valid, 0);
        step(1);
      end
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, (mode == 2'b00));
    check("alu_idle_in_resp", {alu_en, alu_op1_en, alu_op2_en}, 3'b000);
    step(1);
    exp_done++;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("busy_after_hs", busy, 0);
    check("done_cnt", done_cnt, 8'(exp_done));
  endtask

  task automatic check_all_zero();
    check("rst_alu", {alu_en, alu_op1_en, alu_op2_en}, 0);
    check("rst_operands", {alu_operand1, alu_operand2, alu_op1_op, alu_op2_op}, 0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_ready", req_ready, 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, 2'b00, 3'd0, 5'd0, 5'd0);
    step(2);
    check_all_zero();
    rst_n = 1'b1;
    step(1);

    run_cmd(0, 2'b10, 3'b000, 5'd5, 5'd3, 6'd8);
    run_cmd(1, 2'b10, 3'b001, 5'h10, 5'd1, 6'h2F);
    run_cmd(0, 2'b11, 3'b011, 5'd1, 5'd7, 6'd9);
    run_cmd(1, 2'b00, 3'b101, 5'd9, 5'd9, 6'd0);

    // Round-robin with both requesters continuously valid.
    rst_n = 1'b0;
    step(1);
    check("rst_done_cnt_clear", done_cnt, 0);
    rst_n = 1'b1;
    exp_done = 0;
    set_req(0, 2'b10, 3'd0, 5'd3, 5'd4);
    set_req(1, 2'b10, 3'd1, 5'd2, 5'd5);
    req_valid = 2'b11;
    #1;
    check("rr_first_grant", req_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!rsp_valid && w < 20) begin
        step(1);
        w++;
      end
      check("rr_rsp_timeout", rsp_valid, 1);
      check("rr_id", rsp_id, k % 2);
      check("rr_data", rsp_data, (k % 2) ? 6'h3D : 6'd7);
      if (k == 3) req_valid = 2'b00;
      step(1);
    end
    check("rr_done_cnt", done_cnt, 4);
    check("rr_busy", busy, 0);

    // Backpressure, then reset during ISSUE.
    rsp_ready = 1'b0;
    set_req(0, 2'b10, 3'd0, 5'd1, 5'd2);
    req_valid = 2'b01;
    step(4);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b100, 6'd3});
      check("bp_ready", req_ready, 2'b00);
      check("bp_alu_en", alu_en, 0);
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    check("bp_done_cnt", done_cnt, 5);
    check("rr_after_bp", req_ready, 2'b10);
    step(1);
    check("issue_before_rst", alu_en, 1);
    req_valid = 2'b00;
    rst_n = 1'b0;
    step(1);
    check_all_zero();
    rst_n = 1'b1;
    step(6);
    check("no_rsp_after_rst", {rsp_valid, busy}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
